// File: rtl/conv_loop_scheduler.sv
// Convolution loop-nest scheduler: walks (og, y, x, ky, kx, icw) once per start
// and presents one SRAM-address/accumulator-control step per valid/ready handshake.
module conv_loop_scheduler #(
    parameter int unsigned FEATURE_MAP_WIDTH  = 56,
    parameter int unsigned FEATURE_MAP_HEIGHT = 56,
    parameter int unsigned INPUT_NB_CHANNELS  = 64,
    parameter int unsigned OUTPUT_NB_CHANNELS = 64,
    parameter int unsigned KERNEL_SIZE        = 3,
    parameter int unsigned CH_PER_WORD        = 16,
    parameter int unsigned OC_PER_GROUP       = 16,
    parameter int unsigned ADDR_WIDTH_ACT     = 14,
    parameter int unsigned ADDR_WIDTH_WEIGHTS = 12
) (
    input  logic                          clk,
    input  logic                          srst_in,
    input  logic                          start,
    output logic                          running,
    output logic                          done,
    output logic                          step_valid,
    input  logic                          step_ready,
    output logic [ADDR_WIDTH_ACT-1:0]     act_addr,
    output logic                          act_rd_en,
    output logic                          pad_zero,
    output logic [ADDR_WIDTH_WEIGHTS-1:0] wgt_addr,
    output logic                          first_acc,
    output logic                          last_acc,
    output logic [ADDR_WIDTH_ACT-1:0]     out_addr
);

    localparam int unsigned PAD       = (KERNEL_SIZE - 1) / 2;
    localparam int unsigned IC_WORDS  = INPUT_NB_CHANNELS / CH_PER_WORD;
    localparam int unsigned OC_GROUPS = OUTPUT_NB_CHANNELS / OC_PER_GROUP;

    localparam int unsigned ICW_W = (IC_WORDS > 1)           ? $clog2(IC_WORDS)           : 1;
    localparam int unsigned K_W   = (KERNEL_SIZE > 1)        ? $clog2(KERNEL_SIZE)        : 1;
    localparam int unsigned X_W   = (FEATURE_MAP_WIDTH > 1)  ? $clog2(FEATURE_MAP_WIDTH)  : 1;
    localparam int unsigned Y_W   = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
    localparam int unsigned OG_W  = (OC_GROUPS > 1)          ? $clog2(OC_GROUPS)          : 1;

    // Signed copies so tap coordinates can go negative at the map edge.
    localparam int W_S   = int'(FEATURE_MAP_WIDTH);
    localparam int H_S   = int'(FEATURE_MAP_HEIGHT);
    localparam int K_S   = int'(KERNEL_SIZE);
    localparam int ICW_S = int'(IC_WORDS);
    localparam int PAD_S = int'(PAD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ICW_W-1:0]  icw_q, icw_d;
    logic [K_W-1:0]    kx_q, kx_d;
    logic [K_W-1:0]    ky_q, ky_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [OG_W-1:0]   og_q, og_d;

    logic                          running_q, running_d;
    logic                          done_q, done_d;
    logic                          valid_q, valid_d;
    logic [ADDR_WIDTH_ACT-1:0]     act_addr_q, act_addr_d;
    logic                          act_rd_en_q, act_rd_en_d;
    logic                          pad_zero_q, pad_zero_d;
    logic [ADDR_WIDTH_WEIGHTS-1:0] wgt_addr_q, wgt_addr_d;
    logic                          first_q, first_d;
    logic                          last_q, last_d;
    logic [ADDR_WIDTH_ACT-1:0]     out_addr_q, out_addr_d;

    logic icw_last, kx_last, ky_last, x_last, y_last, og_last, final_step;
    int   iy, ix, act_full, wgt_full, out_full;
    logic pad;

    assign icw_last   = (icw_q == ICW_W'(IC_WORDS - 1));
    assign kx_last    = (kx_q  == K_W'(KERNEL_SIZE - 1));
    assign ky_last    = (ky_q  == K_W'(KERNEL_SIZE - 1));
    assign x_last     = (x_q   == X_W'(FEATURE_MAP_WIDTH - 1));
    assign y_last     = (y_q   == Y_W'(FEATURE_MAP_HEIGHT - 1));
    assign og_last    = (og_q  == OG_W'(OC_GROUPS - 1));
    assign final_step = icw_last && kx_last && ky_last && x_last && y_last && og_last;

    // Next state and loop counters; counters only move on an accepted step.
    always_comb begin
        state_d = state_q;
        icw_d   = icw_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        x_d     = x_q;
        y_d     = y_q;
        og_d    = og_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (step_ready) begin
                    icw_d = icw_last ? '0 : icw_q + ICW_W'(1);
                    if (icw_last)
                        kx_d = kx_last ? '0 : kx_q + K_W'(1);
                    if (icw_last && kx_last)
                        ky_d = ky_last ? '0 : ky_q + K_W'(1);
                    if (icw_last && kx_last && ky_last)
                        x_d = x_last ? '0 : x_q + X_W'(1);
                    if (icw_last && kx_last && ky_last && x_last)
                        y_d = y_last ? '0 : y_q + Y_W'(1);
                    if (icw_last && kx_last && ky_last && x_last && y_last)
                        og_d = og_last ? '0 : og_q + OG_W'(1);
                    if (final_step) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Step fields for the next cycle, derived from the next counter values.
    always_comb begin
        running_d   = (state_d == RUN);
        done_d      = (state_d == DONE);
        valid_d     = (state_d == RUN);
        act_addr_d  = '0;
        act_rd_en_d = 1'b0;
        pad_zero_d  = 1'b0;
        wgt_addr_d  = '0;
        first_d     = 1'b0;
        last_d      = 1'b0;
        out_addr_d  = '0;
        iy          = int'(32'(y_d)) + int'(32'(ky_d)) - PAD_S;
        ix          = int'(32'(x_d)) + int'(32'(kx_d)) - PAD_S;
        pad         = (iy < 0) || (iy >= H_S) || (ix < 0) || (ix >= W_S);
        act_full    = (iy * W_S + ix) * ICW_S + int'(32'(icw_d));
        wgt_full    = ((int'(32'(og_d)) * K_S + int'(32'(ky_d))) * K_S + int'(32'(kx_d))) * ICW_S
                      + int'(32'(icw_d));
        out_full    = (int'(32'(og_d)) * H_S + int'(32'(y_d))) * W_S + int'(32'(x_d));
        if (valid_d) begin
            pad_zero_d  = pad;
            act_rd_en_d = !pad;
            act_addr_d  = pad ? '0 : ADDR_WIDTH_ACT'(act_full);
            wgt_addr_d  = ADDR_WIDTH_WEIGHTS'(wgt_full);
            out_addr_d  = ADDR_WIDTH_ACT'(out_full);
            first_d     = (ky_d == '0) && (kx_d == '0) && (icw_d == '0);
            last_d      = (ky_d == K_W'(KERNEL_SIZE - 1)) && (kx_d == K_W'(KERNEL_SIZE - 1))
                          && (icw_d == ICW_W'(IC_WORDS - 1));
        end
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst_in) begin
            state_q     <= IDLE;
            icw_q       <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            og_q        <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            act_addr_q  <= '0;
            act_rd_en_q <= 1'b0;
            pad_zero_q  <= 1'b0;
            wgt_addr_q  <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            out_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            icw_q       <= icw_d;
            kx_q        <= kx_d;
            ky_q        <= ky_d;
            x_q         <= x_d;
            y_q         <= y_d;
            og_q        <= og_d;
            running_q   <= running_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            act_addr_q  <= act_addr_d;
            act_rd_en_q <= act_rd_en_d;
            pad_zero_q  <= pad_zero_d;
            wgt_addr_q  <= wgt_addr_d;
            first_q     <= first_d;
            last_q      <= last_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign running    = running_q;
    assign done       = done_q;
    assign step_valid = valid_q;
    assign act_addr   = act_addr_q;
    assign act_rd_en  = act_rd_en_q;
    assign pad_zero   = pad_zero_q;
    assign wgt_addr   = wgt_addr_q;
    assign first_acc  = first_q;
    assign last_acc   = last_q;
    assign out_addr   = out_addr_q;

endmodule

// File: tb/tb_conv_loop_scheduler.sv
// Self-checking bench for conv_loop_scheduler: scoreboard of expected steps per run.
module tb_conv_loop_scheduler;

    typedef struct packed {
        logic        pad;
        logic        rd_en;
        logic        first;
        logic        last;
        logic [13:0] act;
        logic [11:0] wgt;
        logic [13:0] out;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4x4 map, 1 input word, 1 output group (144 steps)
    logic a_srst, a_start, a_ready;
    logic a_running, a_done, a_valid, a_rd, a_pad, a_first, a_last;
    logic [13:0] a_act, a_out;
    logic [11:0] a_wgt;

    // Instance B: 8x8 map, 2 input words, 2 output groups (2304 steps)
    logic b_srst, b_start, b_ready;
    logic b_running, b_done, b_valid, b_rd, b_pad, b_first, b_last;
    logic [13:0] b_act, b_out;
    logic [11:0] b_wgt;

    conv_loop_scheduler #(
        .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4), .INPUT_NB_CHANNELS(16),
        .OUTPUT_NB_CHANNELS(16), .KERNEL_SIZE(3), .CH_PER_WORD(16), .OC_PER_GROUP(16),
        .ADDR_WIDTH_ACT(14), .ADDR_WIDTH_WEIGHTS(12)
    ) dut_a (
        .clk(clk), .srst_in(a_srst), .start(a_start), .running(a_running), .done(a_done),
        .step_valid(a_valid), .step_ready(a_ready), .act_addr(a_act), .act_rd_en(a_rd),
        .pad_zero(a_pad), .wgt_addr(a_wgt), .first_acc(a_first), .last_acc(a_last),
        .out_addr(a_out)
    );

    conv_loop_scheduler #(
        .FEATURE_MAP_WIDTH(8), .FEATURE_MAP_HEIGHT(8), .INPUT_NB_CHANNELS(32),
        .OUTPUT_NB_CHANNELS(32), .KERNEL_SIZE(3), .CH_PER_WORD(16), .OC_PER_GROUP(16),
        .ADDR_WIDTH_ACT(14), .ADDR_WIDTH_WEIGHTS(12)
    ) dut_b (
        .clk(clk), .srst_in(b_srst), .start(b_start), .running(b_running), .done(b_done),
        .step_valid(b_valid), .step_ready(b_ready), .act_addr(b_act), .act_rd_en(b_rd),
        .pad_zero(b_pad), .wgt_addr(b_wgt), .first_acc(b_first), .last_acc(b_last),
        .out_addr(b_out)
    );

    step_t a_obs, b_obs;
    assign a_obs = {a_pad, a_rd, a_first, a_last, a_act, a_wgt, a_out};
    assign b_obs = {b_pad, b_rd, b_first, b_last, b_act, b_wgt, b_out};

    step_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Reference value of one step from its loop indices.
    function automatic step_t model(int w, int h, int k, int icws,
                                    int og, int y, int x, int ky, int kx, int icw);
        step_t s;
        int p  = (k - 1) / 2;
        int iy = y + ky - p;
        int ix = x + kx - p;
        s.pad   = (iy < 0) || (iy >= h) || (ix < 0) || (ix >= w);
        s.rd_en = !s.pad;
        s.act   = s.pad ? 14'd0 : 14'((iy * w + ix) * icws + icw);
        s.wgt   = 12'(((og * k + ky) * k + kx) * icws + icw);
        s.first = (ky == 0) && (kx == 0) && (icw == 0);
        s.last  = (ky == k - 1) && (kx == k - 1) && (icw == icws - 1);
        s.out   = 14'((og * h + y) * w + x);
        return s;
    endfunction

    task automatic fill(input int w, input int h, input int k, input int icws, input int ocg);
        sb_q.delete();
        for (int og = 0; og < ocg; og++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++)
                            for (int icw = 0; icw < icws; icw++)
                                sb_q.push_back(model(w, h, k, icws, og, y, x, ky, kx, icw));
    endtask

    // Drive one layer on instance A and score every accepted step.
    // mode: 0 ready high, 1 random ready, 2 ready low for 30 cycles then high.
    task automatic run_a(input int mode, input int abort_at, input int inject_at,
                         input bit named, input bit start_in_done, output int nacc);
        int    cycles;
        int    ndone;
        bit    was_final;
        bit    holding;
        step_t held;
        step_t exp_s;
        fill(4, 4, 3, 1, 1);
        nacc = 0; ndone = 0; was_final = 0; holding = 0; held = '0;
        a_ready = (mode == 0) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        n_checks++;
        if (a_running !== 1'b1 || a_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL running_after_start: running=%b valid=%b, required 1 1", a_running, a_valid);
        end
        cycles = 0;
        while (cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (a_done === 1'b1) ndone++;
            if (was_final) begin
                n_checks++;
                if (a_done !== 1'b1 || a_running !== 1'b0 || a_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_cycle: done=%b running=%b valid=%b, required 1 0 0",
                             a_done, a_running, a_valid);
                end
                if (start_in_done) begin
                    a_start = 1'b1;
                    @(posedge clk); #1 a_start = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        if (a_running === 1'b1 || a_valid === 1'b1) ndone = 100;
                    end
                    n_checks++;
                    if (ndone >= 100) begin
                        n_fail++;
                        $display("FAIL start_in_done: layer restarted, required idle");
                    end
                end
                break;
            end
            if (holding) begin
                n_checks++;
                if (a_obs !== held) begin
                    n_fail++;
                    $display("FAIL stall_stable step %0d: got %h, required %h", nacc, a_obs, held);
                end
            end
            holding = 1'b0;
            if (a_valid === 1'b1 && a_ready === 1'b0) begin
                held    = a_obs;
                holding = 1'b1;
            end
            if (a_valid === 1'b1 && a_ready === 1'b1) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_step: got %h, required no step", a_obs);
                end else begin
                    exp_s = sb_q.pop_front();
                    if (a_obs !== exp_s) begin
                        n_fail++;
                        $display("FAIL step %0d: got %h, required %h", nacc, a_obs, exp_s);
                    end
                end
                if (named) begin
                    case (nacc)
                        0: begin
                            n_checks++;
                            if ({a_pad, a_rd, a_act, a_wgt, a_first} !== {1'b1, 1'b0, 14'd0, 12'd0, 1'b1}) begin
                                n_fail++;
                                $display("FAIL step0_fields: pad=%b rd=%b act=%0d wgt=%0d first=%b, required 1 0 0 0 1",
                                         a_pad, a_rd, a_act, a_wgt, a_first);
                            end
                        end
                        4: begin
                            n_checks++;
                            if ({a_pad, a_act, a_wgt} !== {1'b0, 14'd0, 12'd4}) begin
                                n_fail++;
                                $display("FAIL step4_fields: pad=%b act=%0d wgt=%0d, required 0 0 4",
                                         a_pad, a_act, a_wgt);
                            end
                        end
                        8, 17, 143: begin
                            n_checks++;
                            if (a_last !== 1'b1 || a_out !== 14'((nacc == 8) ? 0 : (nacc == 17) ? 1 : 15)) begin
                                n_fail++;
                                $display("FAIL last_acc step %0d: last=%b out=%0d", nacc, a_last, a_out);
                            end
                        end
                        139: begin
                            n_checks++;
                            if ({a_pad, a_act} !== {1'b0, 14'd15}) begin
                                n_fail++;
                                $display("FAIL step139: pad=%b act=%0d, required 0 15", a_pad, a_act);
                            end
                        end
                        140, 142: begin
                            n_checks++;
                            if ({a_pad, a_rd, a_act} !== {1'b1, 1'b0, 14'd0}) begin
                                n_fail++;
                                $display("FAIL edge_pad step %0d: pad=%b rd=%b act=%0d, required 1 0 0",
                                         nacc, a_pad, a_rd, a_act);
                            end
                        end
                        default: ;
                    endcase
                end
                nacc++;
                if (sb_q.size() == 0) was_final = 1'b1;
            end
            if (abort_at >= 0 && nacc == abort_at) break;
            @(posedge clk); #1;
            if (mode == 1) a_ready = 1'($urandom_range(0, 1));
            if (mode == 2) a_ready = (cycles >= 30);
            a_start = (inject_at >= 0 && nacc == inject_at);
        end
        a_start = 1'b0;
        if (cycles >= 2000) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: %0d steps accepted before bound", nacc);
        end
        if (abort_at < 0) begin
            repeat (3) begin
                @(negedge clk);
                if (a_done === 1'b1) ndone++;
            end
            n_checks++;
            if (ndone != 1 && ndone < 100) begin
                n_fail++;
                $display("FAIL done_count: got %0d pulses, required 1", ndone);
            end
        end
    endtask

    task automatic test_reset();
        a_srst = 1'b1; a_start = 1'b1; a_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 a_start = 1'b0;
        n_checks++;
        if ({a_running, a_done, a_valid, a_obs} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b_%b_%b_%h, required all 0", a_running, a_done, a_valid, a_obs);
        end
        @(posedge clk); #1 a_srst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (a_running !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority: running=%b, required 0", a_running);
        end
    endtask

    task automatic test_full_run();
        int nacc;
        run_a(0, -1, -1, 1'b1, 1'b1, nacc);
        n_checks++;
        if (nacc != 144) begin
            n_fail++;
            $display("FAIL full_run_count: got %0d, required 144", nacc);
        end
    endtask

    task automatic test_random_ready();
        int nacc;
        run_a(1, -1, -1, 1'b0, 1'b0, nacc);
        n_checks++;
        if (nacc != 144) begin
            n_fail++;
            $display("FAIL random_ready_count: got %0d, required 144", nacc);
        end
    endtask

    task automatic test_stall();
        int nacc;
        run_a(2, -1, -1, 1'b0, 1'b0, nacc);
        n_checks++;
        if (nacc != 144) begin
            n_fail++;
            $display("FAIL stall_count: got %0d, required 144", nacc);
        end
    endtask

    task automatic test_reset_mid_run();
        int nacc;
        int ndone;
        run_a(0, 50, -1, 1'b0, 1'b0, nacc);
        @(posedge clk); #1 a_srst = 1'b1;
        @(posedge clk); #1 a_srst = 1'b0;
        n_checks++;
        if ({a_running, a_done, a_valid, a_obs} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b_%b_%b_%h, required all 0", a_running, a_done, a_valid, a_obs);
        end
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_done === 1'b1 || a_valid === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: got %0d active cycles, required 0", ndone);
        end
        run_a(0, -1, 30, 1'b1, 1'b0, nacc);
        n_checks++;
        if (nacc != 144) begin
            n_fail++;
            $display("FAIL restart_count: got %0d, required 144", nacc);
        end
    endtask

    task automatic test_multi_group();
        int    nacc, ndone, cycles;
        int    max_act, max_wgt, max_out;
        step_t exp_s;
        fill(8, 8, 3, 2, 2);
        nacc = 0; ndone = 0; max_act = 0; max_wgt = 0; max_out = 0;
        b_ready = 1'b1;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        for (cycles = 0; cycles < 6000 && ndone == 0; cycles++) begin
            @(negedge clk);
            if (b_done === 1'b1) ndone++;
            if (b_valid === 1'b1 && b_ready === 1'b1) begin
                if (int'(b_act) > max_act) max_act = int'(b_act);
                if (int'(b_wgt) > max_wgt) max_wgt = int'(b_wgt);
                if (int'(b_out) > max_out) max_out = int'(b_out);
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_extra_step: got %h", b_obs);
                end else begin
                    exp_s = sb_q.pop_front();
                    if (b_obs !== exp_s) begin
                        n_fail++;
                        $display("FAIL b_step %0d: got %h, required %h", nacc, b_obs, exp_s);
                    end
                end
                nacc++;
            end
            @(posedge clk); #1 b_ready = ($urandom_range(0, 3) != 0);
        end
        n_checks++;
        if (ndone != 1 || nacc != 2304) begin
            n_fail++;
            $display("FAIL b_run: done=%0d steps=%0d, required 1 2304", ndone, nacc);
        end
        n_checks++;
        if (max_act != 127 || max_wgt != 35 || max_out != 127) begin
            n_fail++;
            $display("FAIL b_max_addr: act=%0d wgt=%0d out=%0d, required 127 35 127",
                     max_act, max_wgt, max_out);
        end
    endtask

    initial begin
        a_srst = 1'b1; a_start = 1'b0; a_ready = 1'b0;
        b_srst = 1'b1; b_start = 1'b0; b_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 b_srst = 1'b0;
        test_reset();
        test_full_run();
        test_random_ready();
        test_stall();
        test_reset_mid_run();
        test_multi_group();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
